// File: rtl/cnn_layer_accel_result_packer_if.sv
// Result stream from the accelerator quad and packed-word stream toward the memory write path.
// Both streams use valid/ready semantics: a beat transfers on a rising clock edge where valid and accept/ready are both high.
interface cnn_layer_accel_result_packer_if #(
    parameter int C_RES_WIDTH = 16,
    parameter int C_OUT_WIDTH = 128
);
    logic                                 result_valid;
    logic                                 result_accept;
    logic [C_RES_WIDTH-1:0]               result_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [C_OUT_WIDTH-1:0]               out_data;
    logic [C_OUT_WIDTH/C_RES_WIDTH-1:0]   out_keep;
    logic                                 out_last;

    // master: the surrounding system (quad producer + write-path consumer)
    modport master (
        output result_valid, result_data, out_ready,
        input  result_accept, out_valid, out_data, out_keep, out_last
    );

    // slave: the packer
    modport slave (
        input  result_valid, result_data, out_ready,
        output result_accept, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs the quad's 16-bit result stream into 128-bit words, tracks row/col/depth of each result,
// and zero-pads/flushes the final partial word of a job before pulsing job_done.
module cnn_layer_accel_result_packer #(
    parameter int C_RES_WIDTH = 16,
    parameter int C_OUT_WIDTH = 128,
    parameter int C_CNT_WIDTH = 27
) (
    input  logic                                clk_core,
    input  logic                                rst,
    input  logic                                job_start,
    input  logic [9:0]                          num_output_rows_cfg,
    input  logic [9:0]                          num_output_cols_cfg,
    input  logic [6:0]                          num_kernel_cfg,
    cnn_layer_accel_result_packer_if.slave      bus,
    output logic [9:0]                          output_row,
    output logic [9:0]                          output_col,
    output logic [6:0]                          output_depth,
    output logic                                busy,
    output logic                                job_done,
    output logic [1:0]                          dbg_state_o
);
    localparam int C_LANES     = C_OUT_WIDTH / C_RES_WIDTH;
    localparam int C_LANE_BITS = $clog2(C_LANES);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3} state_e;

    state_e                   state_q, state_d;
    logic [9:0]               rows_q, rows_d, cols_q, cols_d;
    logic [6:0]               kern_q, kern_d;
    logic [C_CNT_WIDTH-1:0]   total_q, total_d, count_q, count_d;
    logic [9:0]               row_q, row_d, col_q, col_d;
    logic [6:0]               depth_q, depth_d;
    logic [C_LANE_BITS-1:0]   lane_q, lane_d;
    logic [C_OUT_WIDTH-1:0]   pack_q, pack_d;
    logic [C_OUT_WIDTH-1:0]   odata_q, odata_d;
    logic [C_LANES-1:0]       okeep_q, okeep_d;
    logic                     ovalid_q, ovalid_d;
    logic                     olast_q, olast_d;

    logic                     accept;
    logic                     take;
    logic                     last_res;
    logic                     word_full;
    logic [C_OUT_WIDTH-1:0]   packed_w;
    logic [C_LANES-1:0]       fill_keep;

    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rows_q   <= '0;
            cols_q   <= '0;
            kern_q   <= '0;
            total_q  <= '0;
            count_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            depth_q  <= '0;
            lane_q   <= '0;
            pack_q   <= '0;
            odata_q  <= '0;
            okeep_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            kern_q   <= kern_d;
            total_q  <= total_d;
            count_q  <= count_d;
            row_q    <= row_d;
            col_q    <= col_d;
            depth_q  <= depth_d;
            lane_q   <= lane_d;
            pack_q   <= pack_d;
            odata_q  <= odata_d;
            okeep_q  <= okeep_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        kern_d   = kern_q;
        total_d  = total_q;
        count_d  = count_q;
        row_d    = row_q;
        col_d    = col_q;
        depth_d  = depth_q;
        lane_d   = lane_q;
        pack_d   = pack_q;
        odata_d  = odata_q;
        okeep_d  = okeep_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;

        // The output register may take a new word whenever it is empty or draining this cycle.
        accept    = (state_q == S_ACTIVE) && (!ovalid_q || bus.out_ready);
        take      = accept && bus.result_valid;
        last_res  = (count_q == (total_q - C_CNT_WIDTH'(1)));
        word_full = (lane_q == C_LANE_BITS'(C_LANES - 1));

        packed_w = pack_q;
        packed_w[int'(lane_q) * C_RES_WIDTH +: C_RES_WIDTH] = bus.result_data;
        for (int i = 0; i < C_LANES; i++) begin
            fill_keep[i] = (i <= int'(lane_q));
        end

        if (ovalid_q && bus.out_ready) begin
            ovalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    if ((num_output_rows_cfg != '0) && (num_output_cols_cfg != '0) &&
                        (num_kernel_cfg != '0)) begin
                        rows_d  = num_output_rows_cfg;
                        cols_d  = num_output_cols_cfg;
                        kern_d  = num_kernel_cfg;
                        total_d = C_CNT_WIDTH'(num_output_rows_cfg) *
                                  C_CNT_WIDTH'(num_output_cols_cfg) *
                                  C_CNT_WIDTH'(num_kernel_cfg);
                        count_d = '0;
                        row_d   = '0;
                        col_d   = '0;
                        depth_d = '0;
                        lane_d  = '0;
                        pack_d  = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACTIVE: begin
                if (take) begin
                    count_d = count_q + C_CNT_WIDTH'(1);
                    // Position wraps col -> row -> depth; after the final result depth lands on kern.
                    if (col_q == cols_q - 10'd1) begin
                        col_d = '0;
                        if (row_q == rows_q - 10'd1) begin
                            row_d   = '0;
                            depth_d = depth_q + 7'd1;
                        end else begin
                            row_d = row_q + 10'd1;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end

                    if (word_full || last_res) begin
                        odata_d  = packed_w;
                        okeep_d  = fill_keep;
                        olast_d  = last_res;
                        ovalid_d = 1'b1;
                        pack_d   = '0;
                        lane_d   = '0;
                    end else begin
                        pack_d = packed_w;
                        lane_d = lane_q + C_LANE_BITS'(1);
                    end

                    if (last_res) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (ovalid_q && bus.out_ready && olast_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.result_accept = accept;
    assign bus.out_valid     = ovalid_q;
    assign bus.out_data      = odata_q;
    assign bus.out_keep      = okeep_q;
    assign bus.out_last      = olast_q;
    assign output_row        = row_q;
    assign output_col        = col_q;
    assign output_depth      = depth_q;
    assign busy              = (state_q != S_IDLE);
    assign job_done          = (state_q == S_DONE);
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Bench for the result packer: table of jobs plus hand-written stall, ignore, zero-cfg and reset sequences.
module tb_cnn_layer_accel_result_packer;
    localparam int RW = 16;
    localparam int OW = 128;
    localparam int NL = 8;
    localparam int EW = OW + NL + 1;

    logic       clk_core = 1'b0;
    logic       rst = 1'b0;
    logic       job_start = 1'b0;
    logic [9:0] num_output_rows_cfg = '0;
    logic [9:0] num_output_cols_cfg = '0;
    logic [6:0] num_kernel_cfg = '0;
    logic [9:0] output_row, output_col;
    logic [6:0] output_depth;
    logic       busy, job_done;
    logic [1:0] dbg_state_o;

    cnn_layer_accel_result_packer_if bus ();

    cnn_layer_accel_result_packer dut (
        .clk_core            (clk_core),
        .rst                 (rst),
        .job_start           (job_start),
        .num_output_rows_cfg (num_output_rows_cfg),
        .num_output_cols_cfg (num_output_cols_cfg),
        .num_kernel_cfg      (num_kernel_cfg),
        .bus                 (bus),
        .output_row          (output_row),
        .output_col          (output_col),
        .output_depth        (output_depth),
        .busy                (busy),
        .job_done            (job_done),
        .dbg_state_o         (dbg_state_o)
    );

    // clock / reset
    always #5 clk_core = ~clk_core;

    int cyc = 0;
    always @(posedge clk_core) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    int words_seen = 0;
    int last_hs_cyc = 0;
    logic [NL-1:0] last_keep_seen = '0;
    logic [OW-1:0] last_data_seen = '0;
    int stalls = 0;
    bit aborted = 0;

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: compare every word handshake against the expected queue
    logic [EW-1:0] mon_e;
    always begin
        @(negedge clk_core);
        #2;
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got data %0h keep %0h last %0b with empty queue",
                         bus.out_data, bus.out_keep, bus.out_last);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_word", {bus.out_data, bus.out_keep, bus.out_last}, mon_e);
            end
            words_seen++;
            last_keep_seen = bus.out_keep;
            last_data_seen = bus.out_data;
            if (bus.out_last) last_hs_cyc = cyc;
        end
    end

    // driver: starts a job and offers results until each is accepted; abort_after<0 runs to completion
    task automatic drive_job(input int rows, input int cols, input int kern, input logic [15:0] first,
                             input int abort_after, input int inject_at);
        int total;
        logic [OW-1:0] word;
        logic [NL-1:0] keep;
        logic [15:0] d;
        bit got;
        int lane;
        total = rows * cols * kern;
        word = '0;
        keep = '0;
        stalls = 0;
        aborted = 0;
        @(negedge clk_core);
        num_output_rows_cfg = 10'(rows);
        num_output_cols_cfg = 10'(cols);
        num_kernel_cfg = 7'(kern);
        job_start = 1'b1;
        @(negedge clk_core);
        job_start = 1'b0;
        for (int n = 0; n < total; n++) begin
            if (n == abort_after) begin
                bus.result_valid = 1'b0;
                return;
            end
            d = (first == 16'h0) ? 16'($urandom_range(0, 65535)) : 16'(first + 16'(n));
            bus.result_valid = 1'b1;
            bus.result_data = d;
            if (n == inject_at) begin
                num_output_rows_cfg = 10'd5;
                num_output_cols_cfg = 10'd5;
                num_kernel_cfg = 7'd5;
                job_start = 1'b1;
            end
            got = 0;
            for (int t = 0; t < 300; t++) begin
                #1;
                if (bus.result_accept) begin
                    got = 1;
                    if (n == 0) chk("busy_active", EW'(busy), EW'(1));
                    chk("pos_col", EW'(output_col), EW'(n % cols));
                    chk("pos_row", EW'(output_row), EW'((n / cols) % rows));
                    chk("pos_depth", EW'(output_depth), EW'(n / (rows * cols)));
                    lane = n % NL;
                    word[lane * RW +: RW] = d;
                    keep[lane] = 1'b1;
                    if (lane == NL - 1 || n == total - 1) begin
                        exp_q.push_back({word, keep, (n == total - 1)});
                        word = '0;
                        keep = '0;
                    end
                end
                @(negedge clk_core);
                job_start = 1'b0;
                if (got) break;
                stalls++;
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: result %0d not accepted within 300 cycles", n);
                bus.result_valid = 1'b0;
                aborted = 1;
                return;
            end
        end
        bus.result_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_core);
            #1;
            if (job_done) begin
                got = 1;
                break;
            end
        end
        chk("job_done_seen", EW'(got), EW'(1));
        if (got) chk("job_done_latency", EW'(cyc), EW'(last_hs_cyc + 1));
        @(negedge clk_core);
        #1;
        chk("job_done_width", EW'(job_done), EW'(0));
        chk("busy_idle", EW'(busy), EW'(0));
    endtask

    task automatic stall_ctrl();
        logic [OW-1:0] hold;
        bit seen;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_core);
            #1;
            if (bus.out_valid) begin
                seen = 1;
                break;
            end
        end
        chk("stall_word0_seen", EW'(seen), EW'(1));
        hold = bus.out_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_core);
            #1;
            chk("stall_valid_held", EW'(bus.out_valid), EW'(1));
            chk("stall_data_stable", EW'(bus.out_data), EW'(hold));
            chk("stall_no_accept", EW'(bus.result_accept), EW'(0));
        end
        @(negedge clk_core);
        bus.out_ready = 1'b1;
    endtask

    typedef struct {
        int rows;
        int cols;
        int kern;
        logic [15:0] first;
        int exp_words;
        logic [7:0] exp_keep;
    } vec_t;

    vec_t tbl[6];
    int w0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2, 2, 2, 16'h0001, 1, 8'hFF};
        tbl[1] = '{3, 3, 1, 16'h0001, 2, 8'h01};
        tbl[2] = '{4, 3, 2, 16'h0100, 3, 8'hFF};
        tbl[3] = '{1, 5, 1, 16'h1000, 1, 8'h1F};
        tbl[4] = '{2, 3, 3, 16'h0000, 3, 8'h03};
        tbl[5] = '{1, 1, 1, 16'h0000, 1, 8'h01};

        bus.result_valid = 1'b0;
        bus.result_data = '0;
        bus.out_ready = 1'b1;

        // reset state
        #12;
        chk("rst_state", EW'(dbg_state_o), EW'(0));
        chk("rst_out_valid", EW'(bus.out_valid), EW'(0));
        chk("rst_accept", EW'(bus.result_accept), EW'(0));
        chk("rst_busy", EW'(busy), EW'(0));
        chk("rst_job_done", EW'(job_done), EW'(0));
        chk("rst_out_data", EW'(bus.out_data), EW'(0));
        @(negedge clk_core);
        rst = 1'b1;

        // results offered while idle must not be taken
        @(negedge clk_core);
        bus.result_valid = 1'b1;
        bus.result_data = 16'hDEAD;
        #1;
        chk("idle_no_accept", EW'(bus.result_accept), EW'(0));
        @(negedge clk_core);
        #1;
        chk("idle_state_kept", EW'(dbg_state_o), EW'(0));
        bus.result_valid = 1'b0;

        // table-driven jobs with continuous out_ready
        for (int i = 0; i < 6; i++) begin
            w0 = words_seen;
            drive_job(tbl[i].rows, tbl[i].cols, tbl[i].kern, tbl[i].first, -1, -1);
            wait_done();
            chk("tbl_words", EW'(words_seen - w0), EW'(tbl[i].exp_words));
            chk("tbl_last_keep", EW'(last_keep_seen), EW'(tbl[i].exp_keep));
            chk("tbl_no_stall", EW'(stalls), EW'(0));
            chk("tbl_queue_empty", EW'(exp_q.size()), EW'(0));
            chk("tbl_sat_pos", EW'({output_depth, output_row, output_col}),
                EW'({7'(tbl[i].kern), 10'd0, 10'd0}));
            if (i == 0)
                chk("word_2x2x2", EW'(last_data_seen), EW'(128'h0008_0007_0006_0005_0004_0003_0002_0001));
            if (i == 1)
                chk("word_3x3x1_tail", EW'(last_data_seen), EW'(128'h9));
        end

        // backpressure: out_ready low for 10 cycles after word0
        w0 = words_seen;
        @(negedge clk_core);
        bus.out_ready = 1'b0;
        fork
            drive_job(4, 4, 1, 16'h0A00, -1, -1);
            stall_ctrl();
        join
        wait_done();
        chk("stall_words", EW'(words_seen - w0), EW'(2));
        chk("stall_queue_empty", EW'(exp_q.size()), EW'(0));

        // job_start during ACTIVE is ignored
        w0 = words_seen;
        drive_job(2, 2, 2, 16'h0040, -1, 3);
        wait_done();
        chk("ignore_words", EW'(words_seen - w0), EW'(1));
        chk("ignore_sat_depth", EW'(output_depth), EW'(2));

        // zero kernel count: straight to DONE, no output word
        w0 = words_seen;
        @(negedge clk_core);
        num_output_rows_cfg = 10'd3;
        num_output_cols_cfg = 10'd3;
        num_kernel_cfg = 7'd0;
        job_start = 1'b1;
        @(negedge clk_core);
        job_start = 1'b0;
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 2; i++) begin
                #1;
                chk("zero_no_valid", EW'(bus.out_valid), EW'(0));
                if (job_done) begin
                    got = 1;
                    break;
                end
                @(negedge clk_core);
            end
            chk("zero_job_done", EW'(got), EW'(1));
        end
        @(negedge clk_core);
        #1;
        chk("zero_done_width", EW'(job_done), EW'(0));
        chk("zero_words", EW'(words_seen - w0), EW'(0));

        // asynchronous reset after 5 of 8 results
        drive_job(2, 2, 2, 16'h0300, 5, -1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_state", EW'(dbg_state_o), EW'(0));
        chk("arst_busy", EW'(busy), EW'(0));
        chk("arst_accept", EW'(bus.result_accept), EW'(0));
        chk("arst_out_valid", EW'(bus.out_valid), EW'(0));
        chk("arst_out_last", EW'(bus.out_last), EW'(0));
        chk("arst_out_keep", EW'(bus.out_keep), EW'(0));
        chk("arst_pos", EW'({output_depth, output_row, output_col}), EW'(0));
        chk("arst_queue_empty", EW'(exp_q.size()), EW'(0));
        @(negedge clk_core);
        rst = 1'b1;
        begin
            int dones;
            dones = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_core);
                #1;
                if (job_done) dones++;
            end
            chk("arst_no_job_done", EW'(dones), EW'(0));
        end
        w0 = words_seen;
        drive_job(2, 2, 2, 16'h0000, -1, -1);
        wait_done();
        chk("post_rst_words", EW'(words_seen - w0), EW'(1));
        chk("post_rst_keep", EW'(last_keep_seen), EW'(8'hFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
